// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an output-stationary ROWS x COLS systolic array.
// Each pass loads the bias into every PE, streams k_len operand columns
// through the skewed array, waits for the wavefront to drain into the far
// corner PE, then offers the result rows one at a time on a valid/ready
// handshake. All outputs are registered and are computed from the next-state
// values, so they line up with the state register.
module systolic_seq_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int KMAX = 16,
    localparam int KW = $clog2(KMAX + 1),
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          load_bias,
    output logic          feed_en,
    output logic [KW-1:0] feed_k,
    output logic          res_valid,
    output logic [RW-1:0] res_row,
    input  logic          res_ready
);

    // Cycle counter must reach the longest stream (KMAX + skew) without wrapping.
    localparam int CW   = $clog2(KMAX + ROWS + COLS + 1);
    // Extra cycles the last operand needs to reach PE(ROWS-1, COLS-1).
    localparam int SKEW = ROWS + COLS - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic [KW-1:0]   klat_q, klat_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            load_bias_q, load_bias_d;
    logic            feed_en_q, feed_en_d;
    logic [KW-1:0]   feed_k_q, feed_k_d;
    logic            res_valid_q, res_valid_d;

    logic [CW-1:0]   stream_len;
    logic            stream_last;
    logic            last_row;

    // A depth above KMAX would overrun the counter; treat it as KMAX.
    function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
        return (k > KW'(KMAX)) ? KW'(KMAX) : k;
    endfunction

    assign stream_len  = CW'(klat_q) + CW'(SKEW);
    assign stream_last = (cnt_q == stream_len - CW'(1));
    assign last_row    = (row_q == RW'(ROWS - 1));

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        klat_d  = klat_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    klat_d  = clamp_k(k_len);
                    cnt_d   = '0;
                    row_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d = '0;
                row_d = '0;
                // A 1x1 array with no operands has nothing to stream or drain.
                if (stream_len == '0) begin
                    state_d = OUT;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (stream_last) begin
                    cnt_d   = '0;
                    row_d   = '0;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OUT: begin
                if (res_ready) begin
                    if (last_row) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cancel wins over everything once a pass is running; in IDLE a
        // concurrent start is still honoured.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
            row_d   = '0;
            done_d  = 1'b0;
        end

        busy_d      = (state_d != IDLE);
        load_bias_d = (state_d == LOAD);
        feed_en_d   = (state_d == STREAM) && (cnt_d < CW'(klat_d));
        feed_k_d    = feed_en_d ? KW'(cnt_d) : '0;
        res_valid_d = (state_d == OUT);
    end

    // State, counters and output registers; reset clears every one of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            klat_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_bias_q <= 1'b0;
            feed_en_q   <= 1'b0;
            feed_k_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            klat_q      <= klat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            load_bias_q <= load_bias_d;
            feed_en_q   <= feed_en_d;
            feed_k_q    <= feed_k_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign load_bias = load_bias_q;
    assign feed_en   = feed_en_q;
    assign feed_k    = feed_k_q;
    assign res_valid = res_valid_q;
    assign res_row   = row_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: a behavioural 4x4 output-stationary
// PE array is driven from the controller outputs and its sums are compared
// against A*B+bias, alongside cycle-by-cycle control output checks.
module tb_systolic_seq_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KMAX = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] k_len = '0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic       load_bias;
    logic       feed_en;
    logic [4:0] feed_k;
    logic       res_valid;
    logic [1:0] res_row;
    logic       res_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .KMAX(KMAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .load_bias (load_bias),
        .feed_en   (feed_en),
        .feed_k    (feed_k),
        .res_valid (res_valid),
        .res_row   (res_row),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    // Operand and bias values.
    function automatic int av(input int i, input int k);
        return i * 3 + k - 5;
    endfunction
    function automatic int bv(input int k, input int j);
        return ((k * j) % 7) - 3;
    endfunction
    function automatic int biasv(input int i, input int j);
        return 10 * i + j;
    endfunction
    function automatic int refv(input int i, input int j, input int k);
        int s;
        s = biasv(i, j);
        for (int kk = 0; kk < k; kk++) s += av(i, kk) * bv(kk, j);
        return s;
    endfunction

    // PE array model: operand column fed at cycle t reaches PE(i,j) at t+i+j;
    // zero-gated edges add nothing; load_bias reloads sums and empties the
    // operand pipeline.
    int tcyc = 0;
    int flush_t = 0;
    bit hen [0:4095];
    int hk  [0:4095];
    int acc [ROWS][COLS];

    always @(posedge clk) begin
        if (tcyc < 4095) tcyc++;
        hen[tcyc] = feed_en;
        hk[tcyc]  = int'(feed_k);
        if (load_bias) begin
            flush_t = tcyc;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) acc[i][j] = biasv(i, j);
        end else begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    int idx;
                    idx = tcyc - i - j;
                    if (idx > flush_t && hen[idx])
                        acc[i][j] += av(i, hk[idx]) * bv(hk[idx], j);
                end
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_lb"}, load_bias, 0);
        chk({tag, "_fe"}, feed_en, 0);
        chk({tag, "_fk"}, feed_k, 0);
        chk({tag, "_rv"}, res_valid, 0);
        chk({tag, "_row"}, res_row, 0);
    endtask

    // One full pass. ab: assert abort with start; hold: keep start high
    // throughout; in_load: the pass has already been accepted.
    task automatic do_pass(input int k, input logic [7:0] pat, input int patlen,
                           input bit ab, input bit hold, input bit in_load);
        int row;
        int p;
        int guard;
        bit rdy;
        if (!in_load) begin
            start = 1'b1;
            k_len = 5'(k);
            abort = ab;
            tick();
        end
        abort = 1'b0;
        if (!hold) start = 1'b0;
        chk("load_lb", load_bias, 1);
        chk("load_busy", busy, 1);
        chk("load_fe", feed_en, 0);
        chk("load_rv", res_valid, 0);
        for (int c = 0; c < k + ROWS + COLS - 2; c++) begin
            tick();
            chk($sformatf("st%0d_lb", c), load_bias, 0);
            chk($sformatf("st%0d_busy", c), busy, 1);
            chk($sformatf("st%0d_fe", c), feed_en, (c < k) ? 1 : 0);
            chk($sformatf("st%0d_fk", c), feed_k, (c < k) ? c : 0);
            chk($sformatf("st%0d_rv", c), res_valid, 0);
        end
        tick();
        row = 0;
        p = 0;
        guard = 0;
        while (row < ROWS && guard < 40) begin
            chk($sformatf("out_rv_r%0d", row), res_valid, 1);
            chk($sformatf("out_row_r%0d", row), res_row, row);
            chk("out_fe", feed_en, 0);
            chk("out_done", done, 0);
            for (int j = 0; j < COLS; j++)
                chk($sformatf("c%0d%0d_k%0d", row, j, k), acc[row][j], refv(row, j, k));
            rdy = (p < patlen) ? pat[p] : 1'b1;
            p++;
            res_ready = rdy;
            tick();
            guard++;
            if (rdy) row++;
        end
        if (guard >= 40) begin
            n_vec++;
            n_err++;
            $error("FAIL out_timeout observed=%0d expected=%0d", row, ROWS);
        end
        res_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_rv", res_valid, 0);
        tick();
        if (hold) begin
            chk("restart_lb", load_bias, 1);
            chk("restart_busy", busy, 1);
            chk("restart_done", done, 0);
        end else begin
            chk("post_done", done, 0);
            chk("post_busy", busy, 0);
        end
    endtask

    initial begin
        // Reset state.
        #1;
        chk_zero("rst");
        tick();
        chk_zero("rst_hold");
        rst = 1'b0;

        // k=3, abort together with start in IDLE, toggling ready.
        tick();
        do_pass(3, 8'b0101_1001, 7, 1'b1, 1'b0, 1'b0);
        chk("hand_c00", acc[0][0], 36);
        chk("hand_c33", acc[3][3], 39);

        // k=0: results equal bias.
        do_pass(0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        chk("hand_bias21", acc[2][1], 21);

        // k=KMAX.
        do_pass(KMAX, 8'h00, 0, 1'b0, 1'b0, 1'b0);

        // Abort at STREAM cnt=2, restart one cycle later.
        start = 1'b1;
        k_len = 5'd3;
        tick();
        start = 1'b0;
        chk("ab_lb", load_bias, 1);
        tick();
        chk("ab_fk0", feed_k, 0);
        tick();
        tick();
        chk("ab_fk2", feed_k, 2);
        chk("ab_fe2", feed_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_zero("ab_idle");
        tick();
        chk_zero("ab_idle2");
        do_pass(3, 8'h00, 0, 1'b0, 1'b0, 1'b0);

        // Reset during OUT at row 2, start held high during the pass.
        start = 1'b1;
        k_len = 5'd2;
        tick();
        chk("rs_lb", load_bias, 1);
        for (int c = 0; c < 2 + ROWS + COLS - 2; c++) tick();
        tick();
        chk("rs_out0", res_row, 0);
        res_ready = 1'b1;
        tick();
        tick();
        res_ready = 1'b0;
        chk("rs_out2", res_row, 2);
        chk("rs_rv", res_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("rs_async");
        start = 1'b0;
        tick();
        chk_zero("rs_held");
        rst = 1'b0;
        tick();
        chk_zero("rs_rel");
        do_pass(2, 8'h00, 0, 1'b0, 1'b1, 1'b0);
        do_pass(2, 8'h00, 0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/systolic_seq_ctrl.md
SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 Parameter ROWS, default 4, number of PE rows in the array being sequenced.
REQ-002 Parameter COLS, default 4, number of PE columns.
REQ-003 Parameter KMAX, default 16, maximum reduction depth; KW = $clog2(KMAX+1).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request a new matrix-multiply pass; sampled only in IDLE.
REQ-007 k_len  input  KW  reduction depth for the pass, 0..KMAX; latched when start is accepted.
REQ-008 abort  input  1  synchronous cancel of the pass in progress.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when the last result row is accepted.
REQ-011 load_bias  output  1  drives every PE load_bias; high only in LOAD.
REQ-012 feed_en  output  1  input buffers present operand column feed_k; when low, the array edge inputs are forced to zero.
REQ-013 feed_k  output  KW  operand column index, valid while feed_en=1.
REQ-014 res_valid  output  1  result row res_row is stable on the PE outputs.
REQ-015 res_row  output  $clog2(ROWS)  index of the result row being offered.
REQ-016 res_ready  input  1  consumer accepts the offered row this cycle.

Function
REQ-017 FSM states: IDLE, LOAD, STREAM, OUT; state register plus a cycle counter cnt (width covering KMAX+ROWS+COLS) and a row counter.
REQ-018 IDLE and start=1: latch k_len, clear cnt, go to LOAD next cycle; start in any other state is ignored.
REQ-019 LOAD lasts exactly 1 cycle, with load_bias=1 and feed_en=0; next state is STREAM with cnt=0.
REQ-020 STREAM lasts exactly k_len+ROWS+COLS-2 cycles, cnt = 0,1,...; feed_en=1 and feed_k=cnt while cnt<k_len, else feed_en=0 and feed_k=0.
REQ-021 STREAM length covers the skew: operand k reaches PE(ROWS-1,COLS-1) at cnt=k+ROWS+COLS-2, so every product is accumulated by the STREAM exit edge.
REQ-022 If k_len=0, STREAM still lasts ROWS+COLS-2 cycles with feed_en never high; the results equal the bias.
REQ-023 When ROWS+COLS-2+k_len=0, i.e. a 1x1 array with k_len=0, STREAM is skipped and LOAD goes directly to OUT.
REQ-024 OUT: res_valid=1 and res_row=row counter, starting at 0; feed_en=0, so the zero-gated PEs hold their sums.
REQ-025 OUT handshake: on res_valid&&res_ready the row counter increments; res_row is held while res_ready=0, and res_valid never drops before acceptance.
REQ-026 Acceptance of row ROWS-1: done=1 for that same cycle's successor, i.e. in the first IDLE cycle only, and the state returns to IDLE.
REQ-027 abort=1 in LOAD, STREAM or OUT: go to IDLE next cycle, with load_bias, feed_en, res_valid and done all 0; in IDLE, abort has no effect.
REQ-028 abort and start in the same IDLE cycle: start is accepted.
REQ-029 load_bias and feed_en are never high in the same cycle; res_valid is never high outside OUT.
REQ-030 A new start is accepted in the cycle done is high, because the state is IDLE by then.

Reset
REQ-031 While rst=1: state=IDLE, all counters 0, latched k_len 0.
REQ-032 While rst=1, every output is 0: busy, done, load_bias, feed_en, feed_k, res_valid, res_row.
REQ-033 Reset asserted mid-pass cancels the pass immediately with no done pulse; the first start after reset release runs a complete pass.

Verification
REQ-034 ROWS=COLS=4, k_len=3, start for 1 cycle -> load_bias high 1 cycle -> feed_en high for 3 cycles with feed_k=0,1,2 -> STREAM 9 cycles -> res_valid; a 4x4 PE array model matches A*B+bias.
REQ-035 OUT with res_ready toggling 1,0,0,1,1,0,1 -> rows 0..3 each accepted exactly once in order; done pulses once, the cycle after row 3 is accepted.
REQ-036 k_len=0 -> STREAM 6 cycles with feed_en=0 throughout; all results equal the loaded bias.
REQ-037 k_len=KMAX=16 -> STREAM 22 cycles, feed_k runs 0..15, no counter wrap.
REQ-038 abort at STREAM cnt=2 -> IDLE next cycle with no done; start issued 1 cycle later -> full pass with correct results.
REQ-039 rst pulsed during OUT with res_row=2 -> all outputs 0 at once; start held high during busy -> ignored; start again after done -> second pass correct.
